// File: rtl/apb_master_pkg.sv
// Shared types and defaults for apb_master.
// Falls back to 32-bit widths when ADDR_WIDTH/DATA_WIDTH are not defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_master_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/apb_master_timeout.sv
// ACCESS-phase wait-state counter; flags the stalled cycle that reaches TIMEOUT_CYCLES.
module apb_master_timeout
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic start,
    input  logic stall,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (stall) begin
            count <= count + 1'b1;
        end
    end

    // Fires in the stalled cycle whose increment would reach the limit, so
    // the transfer spends exactly TIMEOUT_CYCLES cycles in ACCESS.
    assign expired = stall && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: command in, one SETUP + ACCESS transfer, held response out.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [`ADDR_WIDTH-1:0] cmd_addr,
    input  logic [`DATA_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [`DATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_error,
    output logic                   PSELx,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [`ADDR_WIDTH-1:0] PADDR,
    output logic [`DATA_WIDTH-1:0] PWDATA,
    input  logic [`DATA_WIDTH-1:0] PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    state_t state, state_nxt;
    logic   accept, done, timeout, rsp_valid_nxt;

    assign accept  = cmd_valid && cmd_ready;
    assign done    = (state == ST_ACCESS) && (PREADY || timeout);
    assign PSELx   = (state == ST_SETUP) || (state == ST_ACCESS);
    assign PENABLE = (state == ST_ACCESS);

`ifdef APB_MASTER_TIMEOUT_EN
    apb_master_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .start   (state == ST_SETUP),
        .stall   ((state == ST_ACCESS) && !PREADY),
        .expired (timeout)
    );
`else
    // Without the timeout, ACCESS waits for PREADY indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        rsp_valid_nxt = rsp_valid;
        unique case (state)
            ST_IDLE:   if (accept) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (done) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (done)                        rsp_valid_nxt = 1'b1;
        else if (rsp_valid && rsp_ready) rsp_valid_nxt = 1'b0;
    end

    // cmd_ready is registered so it reads 0 throughout reset and rises on the
    // first edge after release; a response consumed this cycle keeps it low.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            cmd_ready <= (state_nxt == ST_IDLE) && !rsp_valid_nxt;
            rsp_valid <= rsp_valid_nxt;
            if (accept) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_write ? cmd_wdata : '0;
            end
            if (done) begin
                rsp_rdata <= (PWRITE || timeout) ? '0 : PRDATA;
                rsp_error <= PSLVERR || timeout;
            end
        end
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max PREADY-low ACCESS cycles before forced abort (used only with the timeout feature).
REQ-002 PCLK  input  1  clock; all logic rising-edge.
REQ-003 PRESETn  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  `ADDR_WIDTH  target address.
REQ-008 cmd_wdata  input  `DATA_WIDTH  write data.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-011 rsp_rdata  output  `DATA_WIDTH  read data; 0 for writes.
REQ-012 rsp_error  output  1  slave error or timeout.
REQ-013 PSELx, PENABLE, PWRITE  output  1 each  APB control to slave.
REQ-014 PADDR  output  `ADDR_WIDTH; PWDATA  output  `DATA_WIDTH  APB address and write data.
REQ-015 PRDATA  input  `DATA_WIDTH; PREADY, PSLVERR  input  1 each  APB slave response.

Function
REQ-016 FSM states: IDLE, SETUP, ACCESS; RESP holds the pending response.
REQ-017 cmd_ready = 1 only in IDLE with rsp_valid = 0.
REQ-018 On acceptance in cycle N, the block registers PADDR, PWRITE, PWDATA (PWDATA = 0 for reads) and enters SETUP in N+1: PSELx=1, PENABLE=0.
REQ-019 SETUP lasts exactly one cycle, then ACCESS: PSELx=1, PENABLE=1.
REQ-020 PADDR, PWRITE, PWDATA hold stable from SETUP through the final ACCESS cycle.
REQ-021 ACCESS repeats while PREADY=0; PREADY is ignored outside ACCESS.
REQ-022 ACCESS cycle with PREADY=1: the block samples PRDATA (reads only) and PSLVERR; next cycle rsp_valid=1, PSELx=0, PENABLE=0, state IDLE.
REQ-023 Minimum latency is 3 cycles from acceptance to rsp_valid, with zero wait states.
REQ-024 rsp_valid, rsp_rdata, rsp_error hold until rsp_valid && rsp_ready; rsp_valid clears the next cycle.
REQ-025 The block accepts no new command while a response is unconsumed, so it never has more than one outstanding transaction.
REQ-026 A cmd_valid asserted in the same cycle the response is consumed is accepted no earlier than the next cycle.

Reset
REQ-027 PRESETn low asynchronously forces state IDLE and drives every output to 0 (cmd_ready, rsp_valid, rsp_rdata, rsp_error, PSELx, PENABLE, PWRITE, PADDR, PWDATA).
REQ-028 Reset during SETUP or ACCESS aborts the transfer without a response; after release, cmd_ready=1 on the first clock edge.

Configuration
REQ-029 Macro APB_MASTER_TIMEOUT_EN defined: a counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
REQ-030 With APB_MASTER_TIMEOUT_EN, on reaching TIMEOUT_CYCLES the block ends the transfer as for PREADY=1, with rsp_error=1 and rsp_rdata=0.
REQ-031 Macro APB_MASTER_TIMEOUT_EN undefined: no counter exists and ACCESS waits indefinitely for PREADY.

Structure
REQ-032 The shared package apb_master_pkg holds the state enum typedef and the TIMEOUT_CYCLES default constant; widths come from the existing ADDR_WIDTH/DATA_WIDTH defines.
REQ-033 One sub-module, apb_master_timeout, contains the timeout counter and is instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-034 Write addr 0x04, data 0xA5, PREADY=1 -> SETUP cycle 1, ACCESS cycle 2, rsp_valid cycle 3, rsp_error=0, rsp_rdata=0.
REQ-035 Read addr 0x08, PREADY low 3 ACCESS cycles, then PRDATA=0x3C with PREADY=1 -> rsp_rdata=0x3C, PADDR stable over all ACCESS cycles.
REQ-036 Write with PSLVERR=1 in the ready cycle -> rsp_error=1, PSELx=0 the next cycle.
REQ-037 rsp_ready held low 5 cycles with cmd_valid high -> cmd_ready=0 throughout; next command is accepted the cycle after rsp_ready=1.
REQ-038 PRESETn pulsed low mid-ACCESS -> all outputs 0 immediately and no rsp_valid; cmd_ready=1 after release.
REQ-039 With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY stuck 0 -> rsp_valid with rsp_error=1 after 4 ACCESS cycles; without the macro, PSELx stays 1 for 100 cycles.
